axis_tx_arbiter: RTL
====================

AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, meaning stream data width in bits.
REQ-002 The block SHALL have parameter KEEP_W, default 32, meaning byte-enable width (DATA_W/8).
REQ-003 The block SHALL have port axis_aclk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-004 The block SHALL have port axis_areset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have ports s0_axis_tvalid/tlast (input, 1), tdata (input, DATA_W), tkeep (input, KEEP_W) and s0_axis_tready (output, 1), forming requester 0's AXI-stream slave.
REQ-006 The block SHALL have ports s1_axis_* identical to s0_axis_*, forming requester 1's slave.
REQ-007 The block SHALL have ports m_axis_tvalid/tlast (output, 1), tdata (output, DATA_W), tkeep (output, KEEP_W) and m_axis_tready (input, 1), forming the shared Aurora TX stream master.
REQ-008 The block SHALL have port grant, output, 2: one-hot current owner, bit0 = s0, bit1 = s1, 00 = none.
REQ-009 The block SHALL have ports pkt_cnt0 and pkt_cnt1, output, 16 each: completed-packet counts per requester.

Function
REQ-010 The FSM SHALL have states IDLE, GNT0 and GNT1; the state, prio pointer, and counters SHALL be registered.
REQ-011 In IDLE, any s*_tvalid high SHALL cause a transition to GNT0 or GNT1 on the next edge.
- If only one requester is valid, that requester SHALL be granted.
- If both are valid, the requester selected by prio SHALL be granted.
- The master outputs SHALL stay idle during the IDLE cycle.
REQ-012 In GNTk, the datapath SHALL be combinational:
- m_axis_tvalid/tdata/tkeep/tlast = sk_axis_*.
- sk_axis_tready = m_axis_tready.
- The other requester's tready = 0.
REQ-013 When not granted, outputs SHALL be m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, and both s*_tready=0.
REQ-014 The grant SHALL be held until a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast is accepted; on that edge:
- state goes to IDLE;
- prio goes to the other requester;
- pkt_cntk increments.
REQ-015 Packet-to-packet latency SHALL be exactly one bubble cycle (IDLE) between the last beat of one packet and the first beat of the next.
REQ-016 A granted source deasserting tvalid mid-packet SHALL NOT release the grant; the FSM SHALL wait in GNTk.
REQ-017 m_axis_tready low SHALL stall the granted source with no beat lost or duplicated.
REQ-018 A single-beat packet (tlast on the first beat) SHALL complete normally and return to IDLE.
REQ-019 pkt_cnt0/1 SHALL wrap 16'hFFFF -> 16'h0000 without saturation or flag.
REQ-020 grant SHALL equal 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE.
REQ-021 Beats with tkeep != all-ones SHALL pass unmodified; the block SHALL NOT inspect tdata or tkeep.

Reset
REQ-022 While axis_areset=1 at a clock edge, the block SHALL set:
- state=IDLE, prio=s0, pkt_cnt0=pkt_cnt1=0, grant=00;
- all m_axis outputs 0 and both s*_tready 0 from the next cycle.
REQ-023 Reset asserted mid-packet SHALL abort the packet immediately, with no tlast generated; after reset release, arbitration SHALL restart from IDLE with prio=s0.

Verification
REQ-024 Both s0 and s1 valid at reset release, each sending a 3-beat packet, m_tready=1 -> s0 beats 1..3, one IDLE cycle, s1 beats 1..3; pkt_cnt0=1, pkt_cnt1=1.
REQ-025 s1 holds a continuous 10-beat packet while s0 asserts valid at beat 2 -> s0 sees tready=0 until s1's tlast is accepted, then s0 is granted after one bubble.
REQ-026 m_tready toggled 1,0,0,1 during an 11-beat packet with tdata 1..11 -> m_axis emits 1..11 exactly once each in order, tlast only on 11.
REQ-027 Sequence of single-beat packets, both sources always valid -> grant alternates 01,00,10,00,01,...; counts increase equally.
REQ-028 Preload 65535 s0 packets (or force pkt_cnt0=16'hFFFF), send one more -> pkt_cnt0=0, pkt_cnt1 unchanged.
REQ-029 axis_areset pulsed for one cycle at beat 4 of a GNT1 packet -> next cycle grant=00, m_tvalid=0, counters 0; next s0+s1 request grants s0 first.

Source files
------------

// File: rtl/axis_tx_arbiter_if.sv
// rtl/axis_tx_arbiter_if.sv - AXI-stream bundle shared by arbiter requesters and the TX master
interface axis_tx_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;

  // Source side of a stream: drives the beat, receives backpressure.
  modport master (
    output tvalid,
    output tlast,
    output tdata,
    output tkeep,
    input  tready
  );

  // Sink side of a stream: receives the beat, drives backpressure.
  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    input  tkeep,
    output tready
  );
endinterface

// File: rtl/axis_tx_arbiter.sv
// rtl/axis_tx_arbiter.sv - two-requester packet arbiter onto one Aurora TX stream
module axis_tx_arbiter #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,
  axis_tx_arbiter_if.slave  s0_axis,
  axis_tx_arbiter_if.slave  s1_axis,
  axis_tx_arbiter_if.master m_axis,
  output logic [1:0]        grant,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_nx;
  logic        prio_q;     // 0: s0 wins a tie, 1: s1 wins a tie
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;
  logic        done0;      // s0's tlast beat accepted this cycle
  logic        done1;

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  // State, tie-break pointer and packet counters; completion hands priority to the other side.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt0_q  <= 16'd0;
      cnt1_q  <= 16'd0;
    end else begin
      state_q <= state_nx;
      if (done0) begin
        prio_q <= 1'b1;
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (done1) begin
        prio_q <= 1'b0;
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  // Arbitration decision and combinational pass-through of the owner's stream.
  always_comb begin
    state_nx       = state_q;
    grant          = 2'b00;
    done0          = 1'b0;
    done1          = 1'b0;
    m_axis.tvalid  = 1'b0;
    m_axis.tlast   = 1'b0;
    m_axis.tdata   = {DATA_W{1'b0}};
    m_axis.tkeep   = {KEEP_W{1'b0}};
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    case (state_q)
      IDLE: begin
        // The bubble cycle: master stays quiet while the next owner is chosen.
        if (s0_axis.tvalid && (!s1_axis.tvalid || !prio_q)) begin
          state_nx = GNT0;
        end else if (s1_axis.tvalid) begin
          state_nx = GNT1;
        end
      end
      GNT0: begin
        grant          = 2'b01;
        m_axis.tvalid  = s0_axis.tvalid;
        m_axis.tlast   = s0_axis.tlast;
        m_axis.tdata   = s0_axis.tdata;
        m_axis.tkeep   = s0_axis.tkeep;
        s0_axis.tready = m_axis.tready;
        done0          = s0_axis.tvalid && m_axis.tready && s0_axis.tlast;
        if (done0) begin
          state_nx = IDLE;
        end
      end
      GNT1: begin
        grant          = 2'b10;
        m_axis.tvalid  = s1_axis.tvalid;
        m_axis.tlast   = s1_axis.tlast;
        m_axis.tdata   = s1_axis.tdata;
        m_axis.tkeep   = s1_axis.tkeep;
        s1_axis.tready = m_axis.tready;
        done1          = s1_axis.tvalid && m_axis.tready && s1_axis.tlast;
        if (done1) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
